// File: rtl/car_pkg.sv
// -----------------------------------------------------------------------------
// car_pkg
// Types shared by the car state collector and its per-channel storage.
//   pos_t              : signed node/centre-of-mass coordinate
//   collector_state_e  : frame collection sequencer states
// POS_W must equal the POSITION_SIZE parameter used for the collector.
// -----------------------------------------------------------------------------
package car_pkg;

  localparam int POS_W = 17;

  typedef logic signed [POS_W-1:0] pos_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    COMMIT  = 2'd2
  } collector_state_e;

endpackage

// File: rtl/collector_channel.sv
// -----------------------------------------------------------------------------
// collector_channel
// One node stream of the car state collector: a saturating write counter,
// the node storage and overflow detection.
//
// Ports
//   clk_in, rst_in   : clock, synchronous active-low reset
//   clear_i          : new frame, counter returns to zero
//   wr_en_i          : collector is accepting samples this cycle
//   valid_i, x_i, y_i: streamed node
//   num_nodes_i      : expected node count for this frame (1..MAX_NODES)
//   wr_bank_i        : bank currently being written (double-buffer build only)
//   snap_x_o/snap_y_o: node storage as seen by the snapshot outputs
//   complete_o       : counter has reached num_nodes_i
//   overflow_o       : a sample arrived after the channel was already full
//
// Build option: COLLECTOR_DOUBLE_BUFFER_EN selects two banks (write bank and
// published bank); without it a single bank is written and published.
// MAX_NODES must be at least 2.
// -----------------------------------------------------------------------------
module collector_channel
  import car_pkg::*;
#(
  parameter int MAX_NODES     = 4,
  parameter int POSITION_SIZE = 17,
  parameter int CNT_W         = $clog2(MAX_NODES) + 1
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic                            clear_i,
  input  logic                            wr_en_i,
  input  logic                            valid_i,
  input  logic signed [POSITION_SIZE-1:0] x_i,
  input  logic signed [POSITION_SIZE-1:0] y_i,
  input  logic [CNT_W-1:0]                num_nodes_i,
`ifdef COLLECTOR_DOUBLE_BUFFER_EN
  input  logic                            wr_bank_i,
`endif
  output logic signed [POSITION_SIZE-1:0] snap_x_o [MAX_NODES],
  output logic signed [POSITION_SIZE-1:0] snap_y_o [MAX_NODES],
  output logic                            complete_o,
  output logic                            overflow_o
);

  localparam int               IDX_W   = $clog2(MAX_NODES);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_NODES);

  logic [CNT_W-1:0] cnt_q;
  logic [IDX_W-1:0] wr_idx_s;
  logic             accept_s;
  logic             overflow_s;

  assign wr_idx_s = cnt_q[IDX_W-1:0];

  // Accept a sample only while below the expected count (and storage depth).
  always_comb begin
    accept_s   = 1'b0;
    overflow_s = 1'b0;
    if (wr_en_i && valid_i) begin
      if ((cnt_q < num_nodes_i) && (cnt_q < MAX_CNT)) begin
        accept_s = 1'b1;
      end else begin
        overflow_s = 1'b1;
      end
    end else begin
      accept_s   = 1'b0;
      overflow_s = 1'b0;
    end
  end

  // Write counter: cleared per frame, saturates instead of wrapping.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      cnt_q <= {CNT_W{1'b0}};
    end else if (clear_i) begin
      cnt_q <= {CNT_W{1'b0}};
    end else if (accept_s) begin
      cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_q <= cnt_q;
    end
  end

`ifdef COLLECTOR_DOUBLE_BUFFER_EN
  logic signed [POSITION_SIZE-1:0] bank_x_q [2][MAX_NODES];
  logic signed [POSITION_SIZE-1:0] bank_y_q [2][MAX_NODES];
  logic                            rd_bank_s;

  assign rd_bank_s = ~wr_bank_i;

  // Node storage, two banks; accepted samples land in the write bank.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      for (int b = 0; b < 2; b++) begin
        for (int n = 0; n < MAX_NODES; n++) begin
          bank_x_q[b][n] <= {POSITION_SIZE{1'b0}};
          bank_y_q[b][n] <= {POSITION_SIZE{1'b0}};
        end
      end
    end else if (accept_s) begin
      bank_x_q[wr_bank_i][wr_idx_s] <= x_i;
      bank_y_q[wr_bank_i][wr_idx_s] <= y_i;
    end
  end

  // Snapshot view is always the bank not being written.
  always_comb begin
    for (int n = 0; n < MAX_NODES; n++) begin
      snap_x_o[n] = bank_x_q[rd_bank_s][n];
      snap_y_o[n] = bank_y_q[rd_bank_s][n];
    end
  end
`else
  logic signed [POSITION_SIZE-1:0] bank_x_q [MAX_NODES];
  logic signed [POSITION_SIZE-1:0] bank_y_q [MAX_NODES];

  // Node storage, single bank; accepted samples are visible next cycle.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      for (int n = 0; n < MAX_NODES; n++) begin
        bank_x_q[n] <= {POSITION_SIZE{1'b0}};
        bank_y_q[n] <= {POSITION_SIZE{1'b0}};
      end
    end else if (accept_s) begin
      bank_x_q[wr_idx_s] <= x_i;
      bank_y_q[wr_idx_s] <= y_i;
    end
  end

  // Snapshot view is the single bank itself.
  always_comb begin
    for (int n = 0; n < MAX_NODES; n++) begin
      snap_x_o[n] = bank_x_q[n];
      snap_y_o[n] = bank_y_q[n];
    end
  end
`endif

  assign complete_o = (cnt_q == num_nodes_i);
  assign overflow_o = overflow_s;

endmodule

// File: rtl/car_state_collector.sv
// -----------------------------------------------------------------------------
// car_state_collector
// Collects streamed node positions (left wheel, right wheel, body) and the
// centre of mass for one physics frame and publishes them as a coherent
// snapshot once every channel delivered its expected node count.
//
// Ports
//   clk_in, rst_in         : clock, synchronous active-low reset
//   frame_start            : open a new frame (clears counters), wins over all_done
//   ch_valid/ch_x/ch_y     : per-channel node stream
//   ch_num_nodes           : expected nodes per channel (1..MAX_NODES)
//   com_valid/com_x/com_y  : centre-of-mass update, last one in a frame wins
//   all_done               : physics engine finished the frame
//   snap_x/snap_y          : published node positions
//   snap_com_x/snap_com_y  : published centre of mass
//   snap_valid             : one-cycle pulse after a successful commit
//   overflow_err           : sticky, a sample arrived for a full channel
//   incomplete_err         : sticky, a frame ended with missing nodes
//
// Build option COLLECTOR_DOUBLE_BUFFER_EN: two banks swapped at commit, so the
// snapshot never changes while a frame is being collected. Without it a
// single bank is written and drives the snapshot directly.
// -----------------------------------------------------------------------------
module car_state_collector
  import car_pkg::*;
#(
  parameter int NUM_CHANNELS  = 3,
  parameter int MAX_NODES     = 4,
  parameter int POSITION_SIZE = 17
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic                            frame_start,
  input  logic                            ch_valid     [NUM_CHANNELS],
  input  logic signed [POSITION_SIZE-1:0] ch_x         [NUM_CHANNELS],
  input  logic signed [POSITION_SIZE-1:0] ch_y         [NUM_CHANNELS],
  input  logic [$clog2(MAX_NODES):0]      ch_num_nodes [NUM_CHANNELS],
  input  logic                            com_valid,
  input  logic signed [POSITION_SIZE-1:0] com_x,
  input  logic signed [POSITION_SIZE-1:0] com_y,
  input  logic                            all_done,
  output logic signed [POSITION_SIZE-1:0] snap_x       [NUM_CHANNELS][MAX_NODES],
  output logic signed [POSITION_SIZE-1:0] snap_y       [NUM_CHANNELS][MAX_NODES],
  output logic signed [POSITION_SIZE-1:0] snap_com_x,
  output logic signed [POSITION_SIZE-1:0] snap_com_y,
  output logic                            snap_valid,
  output logic                            overflow_err,
  output logic                            incomplete_err
);

  collector_state_e state_q, state_d;

  logic                    clear_s;
  logic                    wr_en_s;
  logic                    commit_s;
  logic [NUM_CHANNELS-1:0] complete_s;
  logic [NUM_CHANNELS-1:0] ovf_s;
  logic                    all_complete_s;

  logic snap_valid_q;
  logic overflow_q;
  logic incomplete_q;

  assign all_complete_s = &complete_s;

  // Frame sequencer next state; frame_start outranks all_done.
  always_comb begin
    state_d  = state_q;
    clear_s  = 1'b0;
    wr_en_s  = 1'b0;
    commit_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (frame_start) begin
          state_d = COLLECT;
          clear_s = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      COLLECT: begin
        if (frame_start) begin
          // Pending frame is dropped silently; samples this cycle belong to it.
          state_d = COLLECT;
          clear_s = 1'b1;
        end else begin
          // Samples arriving alongside all_done are still part of this frame.
          wr_en_s = 1'b1;
          if (all_done) begin
            state_d = COMMIT;
          end else begin
            state_d = COLLECT;
          end
        end
      end
      COMMIT: begin
        commit_s = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Frame sequencer state register.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Publish pulse and sticky error flags.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      snap_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      incomplete_q <= 1'b0;
    end else begin
      snap_valid_q <= commit_s & all_complete_s;
      overflow_q   <= overflow_q | (|ovf_s);
      incomplete_q <= incomplete_q | (commit_s & ~all_complete_s);
    end
  end

`ifdef COLLECTOR_DOUBLE_BUFFER_EN
  pos_t com_x_q [2];
  pos_t com_y_q [2];
  logic wr_bank_q;
  logic com_seen_q;

  // Centre-of-mass banks and bank select; swap only on a complete frame.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      com_x_q[0] <= {POS_W{1'b0}};
      com_x_q[1] <= {POS_W{1'b0}};
      com_y_q[0] <= {POS_W{1'b0}};
      com_y_q[1] <= {POS_W{1'b0}};
      wr_bank_q  <= 1'b0;
      com_seen_q <= 1'b0;
    end else if (clear_s) begin
      com_seen_q <= 1'b0;
    end else if (wr_en_s && com_valid) begin
      com_x_q[wr_bank_q] <= com_x;
      com_y_q[wr_bank_q] <= com_y;
      com_seen_q         <= 1'b1;
    end else if (commit_s && all_complete_s) begin
      wr_bank_q <= ~wr_bank_q;
      // No update this frame: carry the published value forward rather than
      // exposing the stale one left in the write bank from two frames ago.
      if (!com_seen_q) begin
        com_x_q[wr_bank_q] <= com_x_q[~wr_bank_q];
        com_y_q[wr_bank_q] <= com_y_q[~wr_bank_q];
      end
    end
  end

  assign snap_com_x = com_x_q[~wr_bank_q];
  assign snap_com_y = com_y_q[~wr_bank_q];
`else
  pos_t com_x_q;
  pos_t com_y_q;

  // Centre-of-mass register; last update of the frame wins.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      com_x_q <= {POS_W{1'b0}};
      com_y_q <= {POS_W{1'b0}};
    end else if (wr_en_s && com_valid) begin
      com_x_q <= com_x;
      com_y_q <= com_y;
    end
  end

  assign snap_com_x = com_x_q;
  assign snap_com_y = com_y_q;
`endif

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
    collector_channel #(
      .MAX_NODES     (MAX_NODES),
      .POSITION_SIZE (POSITION_SIZE)
    ) u_channel (
      .clk_in      (clk_in),
      .rst_in      (rst_in),
      .clear_i     (clear_s),
      .wr_en_i     (wr_en_s),
      .valid_i     (ch_valid[g]),
      .x_i         (ch_x[g]),
      .y_i         (ch_y[g]),
      .num_nodes_i (ch_num_nodes[g]),
`ifdef COLLECTOR_DOUBLE_BUFFER_EN
      .wr_bank_i   (wr_bank_q),
`endif
      .snap_x_o    (snap_x[g]),
      .snap_y_o    (snap_y[g]),
      .complete_o  (complete_s[g]),
      .overflow_o  (ovf_s[g])
    );
  end

  assign snap_valid     = snap_valid_q;
  assign overflow_err   = overflow_q;
  assign incomplete_err = incomplete_q;

endmodule

// File: tb/tb_car_state_collector.sv
// -----------------------------------------------------------------------------
// tb_car_state_collector
// Directed stimulus for car_state_collector with a frame-level reference
// model and a per-cycle compare process. Node values encode frame, channel
// and index so misplaced samples are visible. Honours
// COLLECTOR_DOUBLE_BUFFER_EN to choose which snapshot view is expected.
// -----------------------------------------------------------------------------
module tb_car_state_collector;

  localparam int NCH = 3;
  localparam int MN  = 4;
  localparam int PW  = 17;
  localparam int CW  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_in, frame_start, com_valid, all_done;
  logic                 ch_valid     [NCH];
  logic signed [PW-1:0] ch_x         [NCH];
  logic signed [PW-1:0] ch_y         [NCH];
  logic [CW-1:0]        ch_num_nodes [NCH];
  logic signed [PW-1:0] com_x, com_y;
  logic signed [PW-1:0] snap_x [NCH][MN];
  logic signed [PW-1:0] snap_y [NCH][MN];
  logic signed [PW-1:0] snap_com_x, snap_com_y;
  logic                 snap_valid, overflow_err, incomplete_err;

  car_state_collector #(.NUM_CHANNELS(NCH), .MAX_NODES(MN), .POSITION_SIZE(PW)) dut (
    .clk_in(clk), .rst_in(rst_in), .frame_start(frame_start),
    .ch_valid(ch_valid), .ch_x(ch_x), .ch_y(ch_y), .ch_num_nodes(ch_num_nodes),
    .com_valid(com_valid), .com_x(com_x), .com_y(com_y), .all_done(all_done),
    .snap_x(snap_x), .snap_y(snap_y), .snap_com_x(snap_com_x), .snap_com_y(snap_com_y),
    .snap_valid(snap_valid), .overflow_err(overflow_err), .incomplete_err(incomplete_err)
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;

  // Frame-level model: what the current frame wrote, what was last published.
  int m_num [NCH] = '{4, 4, 3};
  int m_cnt [NCH];
  int m_frame_x [NCH][MN];
  int m_frame_y [NCH][MN];
  int m_pub_x   [NCH][MN];
  int m_pub_y   [NCH][MN];
  int m_frame_cx, m_frame_cy, m_pub_cx, m_pub_cy;
  bit m_com_seen, m_collecting, m_commit_pending;
  bit e_valid, e_ovf, e_inc;

  function automatic int node_x(int f, int c, int k);
    return 1000 * f + 100 * c + k + 1;
  endfunction

  function automatic int node_y(int f, int c, int k);
    return -(1000 * f + 10 * c + k + 1);
  endfunction

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else n_pass++;
  endtask

  // Apply the inputs present at this clock edge to the model.
  task automatic model_edge();
    bit complete;
    if (rst_in !== 1'b1) begin
      for (int c = 0; c < NCH; c++) begin
        m_cnt[c] = 0;
        for (int n = 0; n < MN; n++) begin
          m_frame_x[c][n] = 0; m_frame_y[c][n] = 0;
          m_pub_x[c][n] = 0;   m_pub_y[c][n] = 0;
        end
      end
      m_frame_cx = 0; m_frame_cy = 0; m_pub_cx = 0; m_pub_cy = 0;
      m_com_seen = 0; m_collecting = 0; m_commit_pending = 0;
      e_valid = 0; e_ovf = 0; e_inc = 0;
      return;
    end
    e_valid = 0;
    if (m_commit_pending) begin
      m_commit_pending = 0;
      complete = 1;
      for (int c = 0; c < NCH; c++) if (m_cnt[c] != m_num[c]) complete = 0;
      if (complete) begin
        e_valid = 1;
        for (int c = 0; c < NCH; c++)
          for (int n = 0; n < m_num[c]; n++) begin
            m_pub_x[c][n] = m_frame_x[c][n];
            m_pub_y[c][n] = m_frame_y[c][n];
          end
        if (m_com_seen) begin
          m_pub_cx = m_frame_cx; m_pub_cy = m_frame_cy;
        end
      end else begin
        e_inc = 1;
      end
    end else if (frame_start) begin
      m_collecting = 1;
      m_com_seen = 0;
      for (int c = 0; c < NCH; c++) m_cnt[c] = 0;
    end else if (m_collecting) begin
      for (int c = 0; c < NCH; c++) begin
        if (ch_valid[c]) begin
          if (m_cnt[c] < m_num[c]) begin
            m_frame_x[c][m_cnt[c]] = int'(ch_x[c]);
            m_frame_y[c][m_cnt[c]] = int'(ch_y[c]);
            m_cnt[c]++;
          end else begin
            e_ovf = 1;
          end
        end
      end
      if (com_valid) begin
        m_frame_cx = int'(com_x); m_frame_cy = int'(com_y); m_com_seen = 1;
      end
      if (all_done) begin
        m_collecting = 0; m_commit_pending = 1;
      end
    end
  endtask

  function automatic int exp_x(int c, int n);
`ifdef COLLECTOR_DOUBLE_BUFFER_EN
    return m_pub_x[c][n];
`else
    return m_frame_x[c][n];
`endif
  endfunction

  function automatic int exp_y(int c, int n);
`ifdef COLLECTOR_DOUBLE_BUFFER_EN
    return m_pub_y[c][n];
`else
    return m_frame_y[c][n];
`endif
  endfunction

  function automatic int exp_cx();
`ifdef COLLECTOR_DOUBLE_BUFFER_EN
    return m_pub_cx;
`else
    return m_frame_cx;
`endif
  endfunction

  function automatic int exp_cy();
`ifdef COLLECTOR_DOUBLE_BUFFER_EN
    return m_pub_cy;
`else
    return m_frame_cy;
`endif
  endfunction

  // Compare every output against the model, mid-cycle.
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int c = 0; c < NCH; c++) begin
        for (int n = 0; n < MN; n++) begin
          chk($sformatf("snap_x[%0d][%0d]", c, n), snap_x[c][n], exp_x(c, n));
          chk($sformatf("snap_y[%0d][%0d]", c, n), snap_y[c][n], exp_y(c, n));
        end
      end
      chk("snap_com_x", snap_com_x, exp_cx());
      chk("snap_com_y", snap_com_y, exp_cy());
      chk("snap_valid", snap_valid, e_valid);
      chk("overflow_err", overflow_err, e_ovf);
      chk("incomplete_err", incomplete_err, e_inc);
    end
  end

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    frame_start = 0; all_done = 0; com_valid = 0;
    for (int c = 0; c < NCH; c++) ch_valid[c] = 0;
  endtask

  task automatic drive_nodes(input int f, input int k, input bit [2:0] mask);
    for (int c = 0; c < NCH; c++) begin
      ch_valid[c] = mask[c];
      ch_x[c] = PW'(node_x(f, c, k));
      ch_y[c] = PW'(node_y(f, c, k));
    end
  endtask

  // Send nodes k = 0..3; channel 2 only up to c2_nodes.
  task automatic send_frame(input int f, input int c2_nodes, input bit done_on_last);
    for (int k = 0; k < MN; k++) begin
      drive_nodes(f, k, {(k < c2_nodes), 2'b11});
      all_done = done_on_last && (k == MN - 1);
      step();
      idle();
    end
  endtask

  initial begin
    rst_in = 0; idle();
    com_x = 0; com_y = 0;
    for (int c = 0; c < NCH; c++) begin
      ch_x[c] = 0; ch_y[c] = 0; ch_num_nodes[c] = CW'(m_num[c]);
    end
    step(); cmp_en = 1; step();
    chk("rst_snap_valid", snap_valid, 0);
    chk("rst_snap_x00", snap_x[0][0], 0);
    chk("rst_overflow", overflow_err, 0);
    rst_in = 1; step();

    // Nominal frame 1: 4/4/3 nodes, com updates (5,5) then (12,-7).
    frame_start = 1; step(); idle();
    for (int k = 0; k < MN; k++) begin
      drive_nodes(1, k, {(k < 3), 2'b11});
      if (k == 1) begin com_valid = 1; com_x = 5;  com_y = 5;  end
      if (k == 3) begin com_valid = 1; com_x = 12; com_y = -7; end
      step(); idle();
    end
    all_done = 1; step(); idle();
    chk("nom_commit_cycle", snap_valid, 0);
    step();
    chk("nom_valid", snap_valid, 1);
    chk("nom_com_x", snap_com_x, 12);
    chk("nom_com_y", snap_com_y, -7);
    chk("nom_x22", snap_x[2][2], 1203);
    chk("nom_y13", snap_y[1][3], -1014);
    step();
    chk("nom_pulse_end", snap_valid, 0);

    // Frame 2: fifth sample (99,99) on channel 0 is dropped.
    frame_start = 1; step(); idle();
    send_frame(2, 3, 0);
    ch_valid[0] = 1; ch_x[0] = 99; ch_y[0] = 99; step(); idle();
    all_done = 1; step(); idle(); step();
    chk("ovf_err", overflow_err, 1);
    chk("ovf_valid", snap_valid, 1);
    chk("ovf_x03", snap_x[0][3], 2004);
    chk("ovf_com_kept", snap_com_x, 12);
    step();

    // Frame 3: channel 2 sends only 2 of 3 nodes.
    frame_start = 1; step(); idle();
    send_frame(3, 2, 0);
    all_done = 1; step(); idle(); step();
    chk("inc_err", incomplete_err, 1);
    chk("inc_no_valid", snap_valid, 0);
`ifdef COLLECTOR_DOUBLE_BUFFER_EN
    chk("inc_retained_x20", snap_x[2][0], 2201);
`else
    chk("inc_visible_x20", snap_x[2][0], 3201);
`endif
    step();

    // Frame 4 partial, then frame_start with all_done; frame 5 restarts at 0
    // and channel 1's 4th node arrives in the all_done cycle.
    frame_start = 1; step(); idle();
    drive_nodes(4, 0, 3'b111); step(); idle();
    drive_nodes(4, 1, 3'b111); step(); idle();
    frame_start = 1; all_done = 1; step(); idle();
    chk("same_no_valid", snap_valid, 0);
    send_frame(5, 3, 1);
    chk("bnd_commit_cycle", snap_valid, 0);
    step();
    chk("bnd_valid", snap_valid, 1);
    chk("bnd_y13", snap_y[1][3], -5014);
    chk("bnd_x00", snap_x[0][0], 5001);
    step();

    // Frame 6: reset after 2 nodes, then stimulus in IDLE is ignored.
    frame_start = 1; step(); idle();
    drive_nodes(6, 0, 3'b111); step(); idle();
    drive_nodes(6, 1, 3'b111); step(); idle();
    rst_in = 0; step(); rst_in = 1;
    chk("mid_rst_x00", snap_x[0][0], 0);
    chk("mid_rst_ovf", overflow_err, 0);
    chk("mid_rst_inc", incomplete_err, 0);
    drive_nodes(7, 0, 3'b111); com_valid = 1; com_x = 44; all_done = 1; step(); idle();
    step(); step();
    chk("idle_ignore_x00", snap_x[0][0], 0);
    chk("idle_ignore_com", snap_com_x, 0);
    chk("idle_no_valid", snap_valid, 0);

    // Frame 8: recovery after reset.
    frame_start = 1; step(); idle();
    send_frame(8, 3, 0);
    all_done = 1; step(); idle(); step();
    chk("rec_valid", snap_valid, 1);
    chk("rec_x00", snap_x[0][0], 8001);
    step();

    cmp_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
